// File: rtl/lfsr_bist_ctrl.sv
// LFSR pattern generator with MISR response compaction for built-in self-test.
// One run: load seed, apply count patterns, compact responses, compare signature.
module lfsr_bist_ctrl #(
    parameter int           W    = 8,
    parameter logic [W-1:0] POLY = 8'hB8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] seed,
    input  logic [15:0]  count,
    input  logic [W-1:0] golden,
    input  logic [W-1:0] resp,
    output logic [W-1:0] pat,
    output logic         pat_valid,
    output logic         busy,
    output logic [W-1:0] sig,
    output logic         done,
    output logic         pass,
    output logic         err_seed
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Galois shift shared by the pattern LFSR and the signature MISR.
    function automatic logic [W-1:0] g(input logic [W-1:0] x);
        return (x >> 1) ^ (x[0] ? POLY : '0);
    endfunction

    logic [1:0]   state_q, state_d;
    logic [W-1:0] lfsr_q, lfsr_d;
    logic [W-1:0] misr_q, misr_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [W-1:0] golden_q, golden_d;
    logic [W-1:0] sig_q, sig_d;
    logic         pass_q, pass_d;
    logic         err_seed_q, err_seed_d;

    // Next-state and datapath update for the run sequencer.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        misr_d     = misr_q;
        cnt_d      = cnt_q;
        golden_d   = golden_q;
        sig_d      = sig_q;
        pass_d     = pass_q;
        err_seed_d = err_seed_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_d   = seed;
                    misr_d   = '0;
                    cnt_d    = count;
                    golden_d = golden;
                    sig_d    = '0;
                    pass_d   = 1'b0;
                    if (seed == '0) begin
                        // An all-zero LFSR never advances; flag and skip.
                        err_seed_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        err_seed_d = 1'b0;
                        state_d    = (count == 16'd0) ? S_CHECK : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Abort wins even on the final pattern.
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    lfsr_d = g(lfsr_q);
                    misr_d = g(misr_q) ^ resp;
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                sig_d   = misr_q;
                pass_d  = (misr_q == golden_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= '0;
            misr_q     <= '0;
            cnt_q      <= '0;
            golden_q   <= '0;
            sig_q      <= '0;
            pass_q     <= 1'b0;
            err_seed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            misr_q     <= misr_d;
            cnt_q      <= cnt_d;
            golden_q   <= golden_d;
            sig_q      <= sig_d;
            pass_q     <= pass_d;
            err_seed_q <= err_seed_d;
        end
    end

    assign pat       = lfsr_q;
    assign pat_valid = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sig       = sig_q;
    assign pass      = pass_q;
    assign err_seed  = err_seed_q;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Randomized bench for lfsr_bist_ctrl against a pattern/signature model.
// Directed runs cover the documented examples, aborts and async reset.
module tb_lfsr_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  seed = '0;
    logic [15:0] count = '0;
    logic [7:0]  golden = '0;
    logic [7:0]  resp = '0;
    logic [7:0]  pat;
    logic        pat_valid;
    logic        busy;
    logic [7:0]  sig;
    logic        done;
    logic        pass;
    logic        err_seed;

    int n_pass = 0;
    int n_tot  = 0;

    logic [7:0] rq[$];

    lfsr_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .seed      (seed),
        .count     (count),
        .golden    (golden),
        .resp      (resp),
        .pat       (pat),
        .pat_valid (pat_valid),
        .busy      (busy),
        .sig       (sig),
        .done      (done),
        .pass      (pass),
        .err_seed  (err_seed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] g(input logic [7:0] x);
        return {1'b0, x[7:1]} ^ (x[0] ? 8'hB8 : 8'h00);
    endfunction

    // Signature of the first n responses: fold each into the shifted sum.
    function automatic logic [7:0] sig_of(input int n);
        logic [7:0] a = 8'h00;
        for (int i = 0; i < n; i++) a = g(a) ^ rq[i];
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rand(input int n);
        rq.delete();
        for (int i = 0; i < n; i++) rq.push_back(8'($urandom));
    endtask

    task automatic fill_pat(input logic [7:0] s, input int n);
        logic [7:0] p = s;
        rq.delete();
        for (int i = 0; i < n; i++) begin
            rq.push_back(p);
            p = g(p);
        end
    endtask

    // One run; responses come from rq, abort_at<0 means no abort.
    task automatic run(input logic [7:0] s, input int n,
                       input logic [7:0] gold, input int abort_at,
                       input bit start_mid, input bit start_in_done);
        logic [7:0] p;
        logic [7:0] es;
        abort  = 1'b0;
        start  = 1'b1;
        seed   = s;
        count  = 16'(n);
        golden = gold;
        step();
        start  = 1'b0;
        seed   = 8'($urandom);
        count  = 16'($urandom);
        golden = 8'($urandom);
        if (s == 8'h00) begin
            chk("z_busy", busy, 1);
            chk("z_pv", pat_valid, 0);
            chk("z_done", done, 1);
            chk("z_err", err_seed, 1);
            chk("z_pass", pass, 0);
            chk("z_sig", sig, 0);
            if (start_in_done) begin
                start = 1'b1;
                seed  = 8'h01;
                count = 16'd3;
            end
            step();
            start = 1'b0;
            chk("z_done_end", done, 0);
            chk("z_idle", busy, 0);
            chk("z_err_hold", err_seed, 1);
            return;
        end
        chk("err_clr", err_seed, 0);
        p = s;
        for (int k = 0; k < n; k++) begin
            chk("pv", pat_valid, 1);
            chk("pat", pat, p);
            chk("done_lo", done, 0);
            if (s == 8'h01 && k == 5) chk("pat5", pat, 8'hB3);
            if (s == 8'h01 && k == 255) chk("pat256", pat, 8'h01);
            resp = rq[k];
            if (k == abort_at) abort = 1'b1;
            if (start_mid && k == 1) begin
                start = 1'b1;
                seed  = 8'h77;
                count = 16'd5;
            end
            step();
            abort = 1'b0;
            start = 1'b0;
            if (k == abort_at) begin
                chk("ab_busy", busy, 0);
                chk("ab_pv", pat_valid, 0);
                chk("ab_done", done, 0);
                chk("ab_pass", pass, 0);
                chk("ab_sig", sig, 0);
                step();
                chk("ab_no_done", done, 0);
                chk("ab_stay", busy, 0);
                return;
            end
            p = g(p);
        end
        es = sig_of(n);
        chk("ck_pv", pat_valid, 0);
        chk("ck_busy", busy, 1);
        chk("ck_done", done, 0);
        step();
        chk("dn_done", done, 1);
        chk("dn_busy", busy, 1);
        chk("dn_sig", sig, es);
        chk("dn_pass", pass, (es == gold) ? 1 : 0);
        if (start_in_done) begin
            start = 1'b1;
            seed  = 8'h01;
            count = 16'd3;
        end
        step();
        start = 1'b0;
        chk("end_done", done, 0);
        chk("end_idle", busy, 0);
        chk("end_sig", sig, es);
        chk("end_pass", pass, (es == gold) ? 1 : 0);
    endtask

    initial begin
        #2;
        chk("rst_pat", pat, 0);
        chk("rst_pv", pat_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sig", sig, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_seed, 0);
        step();
        rst = 1'b0;

        fill_pat(8'h01, 3);
        run(8'h01, 3, 8'h5C, -1, 1'b0, 1'b1);
        fill_pat(8'h01, 3);
        run(8'h01, 3, 8'h5D, -1, 1'b0, 1'b0);
        run(8'h00, 3, 8'h12, -1, 1'b0, 1'b1);
        fill_rand(256);
        run(8'h01, 256, 8'h00, -1, 1'b0, 1'b0);
        fill_rand(10);
        run(8'h01, 10, 8'h00, 3, 1'b1, 1'b0);
        fill_rand(3);
        run(8'h2F, 3, 8'h00, 2, 1'b0, 1'b0);
        fill_rand(600);
        run(8'hC3, 600, sig_of(600), -1, 1'b0, 1'b0);

        // Asynchronous reset between edges in the middle of a run.
        start = 1'b1;
        seed  = 8'h01;
        count = 16'd10;
        step();
        start = 1'b0;
        step();
        step();
        #3 rst = 1'b1;
        #1;
        chk("ar_pat", pat, 0);
        chk("ar_pv", pat_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_sig", sig, 0);
        chk("ar_done", done, 0);
        chk("ar_pass", pass, 0);
        chk("ar_err", err_seed, 0);
        #2 rst = 1'b0;
        rq.delete();
        run(8'h01, 0, 8'h00, -1, 1'b0, 1'b0);
        run(8'h5A, 0, 8'h3C, -1, 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            logic [7:0] s;
            int         n;
            int         ab;
            logic [7:0] gd;
            s  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            n  = $urandom_range(0, 20);
            fill_rand(n);
            gd = $urandom_range(0, 1) ? sig_of(n) : 8'($urandom);
            ab = -1;
            if (n > 0 && $urandom_range(0, 3) == 0)
                ab = $urandom_range(0, n - 1);
            run(s, n, gd, ab, 1'($urandom), 1'($urandom));
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                abort = 1'($urandom);
                step();
                chk("gap_idle", busy, 0);
            end
            abort = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
